// File: rtl/ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ctrl_pkg
// Description : Shared encodings and the control word for the RV32I control path
// Revision    : 1.0 - initial release
// ============================================================================
package ctrl_pkg;

    localparam logic [6:0] c_op_r      = 7'b0110011;
    localparam logic [6:0] c_op_i      = 7'b0010011;
    localparam logic [6:0] c_op_load   = 7'b0000011;
    localparam logic [6:0] c_op_store  = 7'b0100011;
    localparam logic [6:0] c_op_branch = 7'b1100011;
    localparam logic [6:0] c_op_jal    = 7'b1101111;
    localparam logic [6:0] c_op_jalr   = 7'b1100111;
    localparam logic [6:0] c_op_lui    = 7'b0110111;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_XOR = 3'd4,
        ALU_SLT = 3'd5,
        ALU_SLL = 3'd6,
        ALU_SRL = 3'd7
    } alu_ctl_e;

    typedef enum logic [2:0] {
        IMM_I = 3'd0,
        IMM_S = 3'd1,
        IMM_B = 3'd2,
        IMM_J = 3'd3,
        IMM_U = 3'd4
    } imm_src_e;

    typedef enum logic [1:0] {
        RES_ALU = 2'd0,
        RES_MEM = 2'd1,
        RES_PC4 = 2'd2,
        RES_IMM = 2'd3
    } result_src_e;

    typedef struct packed {
        logic        reg_write;
        logic        mem_write;
        result_src_e result_src;
        alu_ctl_e    alu_ctl;
        logic        alu_src;
        logic        branch;
        logic [2:0]  funct3;
        logic        jump;
        logic        jalr;
    } ctrl_word_t;

    // All-zero word doubles as the pipeline bubble
    localparam ctrl_word_t c_bubble = '0;

endpackage
`default_nettype wire

// File: rtl/ctrl_pipe_if.sv
`default_nettype none
// ============================================================================
// Module      : ctrl_pipe_if
// Description : Handshake/bus bundle between hazard unit, datapath and ctrl_pipe
// Revision    : 1.0 - initial release
// ============================================================================
interface ctrl_pipe_if #(
    parameter int ALUCTL_W = 3,
    parameter int CNT_W    = 16
);
    logic                valid_d;
    logic [31:0]         instr_d;
    logic                stall_d;
    logic                flush_e;
    logic                zero_e;
    logic                lt_e;
    logic                ltu_e;
    logic                illegal_d;
    logic [ALUCTL_W-1:0] alu_ctl_e;
    logic                alu_src_e;
    logic [2:0]          imm_src_d;
    logic                pc_src_e;
    logic                jalr_e;
    logic                reg_write_m;
    logic                mem_write_m;
    logic                reg_write_w;
    logic [1:0]          result_src_w;
    logic [CNT_W-1:0]    illegal_cnt;

    modport master (
        output valid_d, instr_d, stall_d, flush_e, zero_e, lt_e, ltu_e,
        input  illegal_d, alu_ctl_e, alu_src_e, imm_src_d, pc_src_e, jalr_e,
               reg_write_m, mem_write_m, reg_write_w, result_src_w, illegal_cnt
    );

    modport slave (
        input  valid_d, instr_d, stall_d, flush_e, zero_e, lt_e, ltu_e,
        output illegal_d, alu_ctl_e, alu_src_e, imm_src_d, pc_src_e, jalr_e,
               reg_write_m, mem_write_m, reg_write_w, result_src_w, illegal_cnt
    );
endinterface
`default_nettype wire

// File: rtl/ctrl_decode.sv
`default_nettype none
// ============================================================================
// Module      : ctrl_decode
// Description : D-stage instruction decode and illegal-encoding detection
// Revision    : 1.0 - initial release
// ============================================================================
module ctrl_decode
    import ctrl_pkg::*;
#(
    parameter bit EN_JUMP = 1'b1
) (
    input  logic       i_valid,
    input  logic [6:0] i_opcode,
    input  logic [2:0] i_funct3,
    input  logic       i_funct7b5,
    output ctrl_word_t o_word,
    output imm_src_e   o_imm_src,
    output logic       o_illegal
);

    ctrl_word_t w_dec;
    imm_src_e   w_imm;
    logic       w_ok;
    logic       w_is_r;

    assign w_is_r = (i_opcode == c_op_r);

    always_comb begin
        w_dec = c_bubble;
        w_imm = IMM_I;
        w_ok  = 1'b0;
        case (i_opcode)
            c_op_r, c_op_i: begin
                w_ok            = 1'b1;
                w_dec.reg_write = 1'b1;
                w_dec.alu_src   = ~w_is_r;
                case (i_funct3)
                    3'b000:  w_dec.alu_ctl = (w_is_r && i_funct7b5) ? ALU_SUB : ALU_ADD;
                    3'b001:  w_dec.alu_ctl = ALU_SLL;
                    3'b010:  w_dec.alu_ctl = ALU_SLT;
                    3'b100:  w_dec.alu_ctl = ALU_XOR;
                    3'b101: begin
                        // Arithmetic shifts have no ALU encoding
                        w_dec.alu_ctl = ALU_SRL;
                        if (i_funct7b5) w_ok = 1'b0;
                    end
                    3'b110:  w_dec.alu_ctl = ALU_OR;
                    3'b111:  w_dec.alu_ctl = ALU_AND;
                    default: w_ok = 1'b0;
                endcase
                if (w_is_r && i_funct7b5 && (i_funct3 != 3'b000)) w_ok = 1'b0;
            end
            c_op_load: begin
                if (i_funct3 == 3'b010) begin
                    w_ok             = 1'b1;
                    w_dec.reg_write  = 1'b1;
                    w_dec.alu_src    = 1'b1;
                    w_dec.result_src = RES_MEM;
                end
            end
            c_op_store: begin
                if (i_funct3 == 3'b010) begin
                    w_ok            = 1'b1;
                    w_dec.mem_write = 1'b1;
                    w_dec.alu_src   = 1'b1;
                    w_imm           = IMM_S;
                end
            end
            c_op_branch: begin
                w_ok          = (i_funct3 != 3'b010) && (i_funct3 != 3'b011);
                w_dec.branch  = 1'b1;
                w_dec.alu_ctl = ALU_SUB;
                w_dec.funct3  = i_funct3;
                w_imm         = IMM_B;
            end
            c_op_jal: begin
                if (EN_JUMP) begin
                    w_ok             = 1'b1;
                    w_dec.reg_write  = 1'b1;
                    w_dec.result_src = RES_PC4;
                    w_dec.jump       = 1'b1;
                    w_imm            = IMM_J;
                end
            end
            c_op_jalr: begin
                if (EN_JUMP && (i_funct3 == 3'b000)) begin
                    w_ok             = 1'b1;
                    w_dec.reg_write  = 1'b1;
                    w_dec.result_src = RES_PC4;
                    w_dec.jump       = 1'b1;
                    w_dec.jalr       = 1'b1;
                    w_dec.alu_src    = 1'b1;
                end
            end
            c_op_lui: begin
                if (EN_JUMP) begin
                    w_ok             = 1'b1;
                    w_dec.reg_write  = 1'b1;
                    w_dec.result_src = RES_IMM;
                    w_imm            = IMM_U;
                end
            end
            default: w_ok = 1'b0;
        endcase
    end

    assign o_word    = w_ok ? w_dec : c_bubble;
    assign o_imm_src = w_ok ? w_imm : IMM_I;
    assign o_illegal = i_valid & ~w_ok;

endmodule
`default_nettype wire

// File: rtl/ctrl_pipe.sv
`default_nettype none
// ============================================================================
// Module      : ctrl_pipe
// Description : ID/EX, EX/MEM, MEM/WB control registers, branch resolution and
//               illegal-instruction counter for the 5-stage RV32I core
// Revision    : 1.0 - initial release
// ============================================================================
module ctrl_pipe
    import ctrl_pkg::*;
#(
    parameter int ALUCTL_W = 3,
    parameter int CNT_W    = 16,
    parameter bit EN_JUMP  = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    ctrl_pipe_if.slave bus
);

    ctrl_word_t       w_word;
    imm_src_e         w_imm_src;
    logic             w_illegal;
    logic             w_taken;
    logic             w_cnt_inc;

    ctrl_word_t       r_e;
    logic             r_m_reg_write;
    logic             r_m_mem_write;
    result_src_e      r_m_result_src;
    logic             r_w_reg_write;
    result_src_e      r_w_result_src;
    logic [CNT_W-1:0] r_cnt;

    ctrl_decode #(
        .EN_JUMP (EN_JUMP)
    ) u_decode (
        .i_valid    (bus.valid_d),
        .i_opcode   (bus.instr_d[6:0]),
        .i_funct3   (bus.instr_d[14:12]),
        .i_funct7b5 (bus.instr_d[30]),
        .o_word     (w_word),
        .o_imm_src  (w_imm_src),
        .o_illegal  (w_illegal)
    );

    always_ff @(posedge clk) begin
        if (rst || bus.flush_e || bus.stall_d || !bus.valid_d) begin
            r_e <= c_bubble;
        end else begin
            r_e <= w_word;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_m_reg_write  <= 1'b0;
            r_m_mem_write  <= 1'b0;
            r_m_result_src <= RES_ALU;
            r_w_reg_write  <= 1'b0;
            r_w_result_src <= RES_ALU;
        end else begin
            r_m_reg_write  <= r_e.reg_write;
            r_m_mem_write  <= r_e.mem_write;
            r_m_result_src <= r_e.result_src;
            r_w_reg_write  <= r_m_reg_write;
            r_w_result_src <= r_m_result_src;
        end
    end

    // A held instruction is only counted on the cycle it actually leaves D
    assign w_cnt_inc = w_illegal & ~bus.stall_d & ~bus.flush_e;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (w_cnt_inc && (r_cnt != {CNT_W{1'b1}})) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    always_comb begin
        w_taken = 1'b0;
        case (r_e.funct3)
            3'b000:  w_taken = bus.zero_e;
            3'b001:  w_taken = ~bus.zero_e;
            3'b100:  w_taken = bus.lt_e;
            3'b101:  w_taken = ~bus.lt_e;
            3'b110:  w_taken = bus.ltu_e;
            3'b111:  w_taken = ~bus.ltu_e;
            default: w_taken = 1'b0;
        endcase
    end

    assign bus.illegal_d    = w_illegal;
    assign bus.imm_src_d    = w_imm_src;
    assign bus.alu_ctl_e    = ALUCTL_W'(r_e.alu_ctl);
    assign bus.alu_src_e    = r_e.alu_src;
    assign bus.pc_src_e     = (r_e.branch & w_taken) | r_e.jump;
    assign bus.jalr_e       = r_e.jalr;
    assign bus.reg_write_m  = r_m_reg_write;
    assign bus.mem_write_m  = r_m_mem_write;
    assign bus.reg_write_w  = r_w_reg_write;
    assign bus.result_src_w = r_w_result_src;
    assign bus.illegal_cnt  = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_ctrl_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_ctrl_pipe
// Description : Directed self-checking bench for ctrl_pipe with a reference model
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ctrl_pipe;

    localparam logic [31:0] c_add   = 32'h002081B3;
    localparam logic [31:0] c_sub   = 32'h402081B3;
    localparam logic [31:0] c_andi  = 32'h0050F193;
    localparam logic [31:0] c_srai  = 32'h4010D193;
    localparam logic [31:0] c_sltu  = 32'h0020B1B3;
    localparam logic [31:0] c_xor   = 32'h0020C1B3;
    localparam logic [31:0] c_sll   = 32'h002091B3;
    localparam logic [31:0] c_slli  = 32'h00109193;
    localparam logic [31:0] c_slt   = 32'h0020A1B3;
    localparam logic [31:0] c_srl   = 32'h0020D1B3;
    localparam logic [31:0] c_or    = 32'h0020E1B3;
    localparam logic [31:0] c_lw    = 32'h0000A283;
    localparam logic [31:0] c_lb    = 32'h00008283;
    localparam logic [31:0] c_sw    = 32'h0020A023;
    localparam logic [31:0] c_beq   = 32'h00208063;
    localparam logic [31:0] c_bne   = 32'h00209063;
    localparam logic [31:0] c_blt   = 32'h0020C063;
    localparam logic [31:0] c_bge   = 32'h0020D063;
    localparam logic [31:0] c_bltu  = 32'h0020E063;
    localparam logic [31:0] c_bgeu  = 32'h0020F063;
    localparam logic [31:0] c_b010  = 32'h0020A063;
    localparam logic [31:0] c_jal   = 32'h000000EF;
    localparam logic [31:0] c_jalr  = 32'h000080E7;
    localparam logic [31:0] c_lui   = 32'h000120B7;
    localparam logic [31:0] c_op7f  = 32'h0000007F;

    logic        clk = 1'b0;
    logic        rst, valid_d, stall_d, flush_e, zero_e, lt_e, ltu_e;
    logic [31:0] instr_d;
    int          n_chk = 0;
    int          n_pass = 0;

    always #5 clk = ~clk;

    ctrl_pipe_if #(.ALUCTL_W(3), .CNT_W(16)) bus1 ();
    ctrl_pipe_if #(.ALUCTL_W(3), .CNT_W(2))  bus2 ();
    ctrl_pipe_if #(.ALUCTL_W(3), .CNT_W(16)) bus3 ();

    assign bus1.valid_d = valid_d; assign bus1.instr_d = instr_d; assign bus1.stall_d = stall_d;
    assign bus1.flush_e = flush_e; assign bus1.zero_e = zero_e; assign bus1.lt_e = lt_e; assign bus1.ltu_e = ltu_e;
    assign bus2.valid_d = valid_d; assign bus2.instr_d = instr_d; assign bus2.stall_d = stall_d;
    assign bus2.flush_e = flush_e; assign bus2.zero_e = zero_e; assign bus2.lt_e = lt_e; assign bus2.ltu_e = ltu_e;
    assign bus3.valid_d = valid_d; assign bus3.instr_d = instr_d; assign bus3.stall_d = stall_d;
    assign bus3.flush_e = flush_e; assign bus3.zero_e = zero_e; assign bus3.lt_e = lt_e; assign bus3.ltu_e = ltu_e;

    ctrl_pipe #(.ALUCTL_W(3), .CNT_W(16), .EN_JUMP(1'b1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
    ctrl_pipe #(.ALUCTL_W(3), .CNT_W(2),  .EN_JUMP(1'b1)) dut2 (.clk(clk), .rst(rst), .bus(bus2));
    ctrl_pipe #(.ALUCTL_W(3), .CNT_W(16), .EN_JUMP(1'b0)) dut3 (.clk(clk), .rst(rst), .bus(bus3));

    // Reference model: expected control word of one instruction
    typedef struct {
        bit rw; bit mw; int rs; int alu; bit asrc; bit br; int f3; bit jmp; bit jalr;
    } mword_t;

    typedef struct {
        mword_t w; bit legal; int imm;
    } mdec_t;

    function automatic mword_t mbub();
        mword_t b = '{default: 0};
        return b;
    endfunction

    function automatic mdec_t mdl_dec(input logic [31:0] ins, input bit ej);
        mdec_t r;
        int    op  = int'(ins[6:0]);
        int    f3  = int'(ins[14:12]);
        bit    f7b = ins[30];
        int    alu_of_f3 [8] = '{0, 6, 5, -1, 4, 7, 3, 2};
        int    a;
        r.w = mbub(); r.legal = 0; r.imm = 0;
        if (op == 'h33 || op == 'h13) begin
            a = alu_of_f3[f3];
            if (op == 'h33 && f7b)               a = (f3 == 0) ? 1 : -1;
            else if (op == 'h13 && f7b && f3 == 5) a = -1;
            if (a >= 0) begin
                r.legal = 1; r.w.rw = 1; r.w.alu = a; r.w.asrc = (op == 'h13);
            end
        end else if (op == 'h03 && f3 == 2) begin
            r.legal = 1; r.w.rw = 1; r.w.asrc = 1; r.w.rs = 1;
        end else if (op == 'h23 && f3 == 2) begin
            r.legal = 1; r.w.mw = 1; r.w.asrc = 1; r.imm = 1;
        end else if (op == 'h63 && f3 != 2 && f3 != 3) begin
            r.legal = 1; r.w.br = 1; r.w.alu = 1; r.w.f3 = f3; r.imm = 2;
        end else if (ej && op == 'h6F) begin
            r.legal = 1; r.w.rw = 1; r.w.rs = 2; r.w.jmp = 1; r.imm = 3;
        end else if (ej && op == 'h67 && f3 == 0) begin
            r.legal = 1; r.w.rw = 1; r.w.rs = 2; r.w.jmp = 1; r.w.jalr = 1; r.w.asrc = 1;
        end else if (ej && op == 'h37) begin
            r.legal = 1; r.w.rw = 1; r.w.rs = 3; r.imm = 4;
        end
        return r;
    endfunction

    function automatic bit mdl_redirect(input mword_t e, input bit z, input bit lt, input bit ltu);
        bit cond [8] = '{z, !z, 0, 0, lt, !lt, ltu, !ltu};
        return e.jmp || (e.br && cond[e.f3]);
    endfunction

    mdec_t  dcur, dcur3;
    mword_t me, mm, mw;
    int     mcnt1, mcnt2;
    bit     chk_en = 0;

    always_comb dcur  = mdl_dec(instr_d, 1'b1);
    always_comb dcur3 = mdl_dec(instr_d, 1'b0);

    always @(posedge clk) begin
        if (rst) begin
            me <= mbub(); mm <= mbub(); mw <= mbub();
            mcnt1 <= 0; mcnt2 <= 0; chk_en <= 1'b1;
        end else begin
            me <= (valid_d && !stall_d && !flush_e && dcur.legal) ? dcur.w : mbub();
            mm <= me;
            mw <= mm;
            if (valid_d && !dcur.legal && !stall_d && !flush_e) begin
                mcnt1 <= (mcnt1 < 65535) ? mcnt1 + 1 : mcnt1;
                mcnt2 <= (mcnt2 < 3) ? mcnt2 + 1 : mcnt2;
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("m_illegal_d", 32'(bus1.illegal_d), 32'(valid_d && !dcur.legal));
            if (valid_d && dcur.legal) chk("m_imm_src_d", 32'(bus1.imm_src_d), 32'(dcur.imm));
            chk("m_alu_ctl_e",    32'(bus1.alu_ctl_e),    32'(me.alu));
            chk("m_alu_src_e",    32'(bus1.alu_src_e),    32'(me.asrc));
            chk("m_jalr_e",       32'(bus1.jalr_e),       32'(me.jalr));
            chk("m_pc_src_e",     32'(bus1.pc_src_e),     32'(mdl_redirect(me, zero_e, lt_e, ltu_e)));
            chk("m_reg_write_m",  32'(bus1.reg_write_m),  32'(mm.rw));
            chk("m_mem_write_m",  32'(bus1.mem_write_m),  32'(mm.mw));
            chk("m_reg_write_w",  32'(bus1.reg_write_w),  32'(mw.rw));
            chk("m_result_src_w", 32'(bus1.result_src_w), 32'(mw.rs));
            chk("m_illegal_cnt",  32'(bus1.illegal_cnt),  32'(mcnt1));
            chk("m_illegal_cnt2", 32'(bus2.illegal_cnt),  32'(mcnt2));
            chk("m_illegal_d_nj", 32'(bus3.illegal_d),    32'(valid_d && !dcur3.legal));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input logic v, input logic [31:0] ins);
        valid_d = v;
        instr_d = ins;
    endtask

    task automatic do_reset();
        rst = 1'b1; put(1'b0, 32'h0);
        tick();
        rst = 1'b0;
    endtask

    logic [31:0] tbl [24] = '{c_add, c_sub, c_andi, c_srai, c_sltu, c_xor, c_sll, c_slli,
                              c_slt, c_srl, c_or, c_lw, c_lb, c_sw, c_beq, c_bne,
                              c_blt, c_bge, c_bltu, c_bgeu, c_b010, c_jal, c_jalr, c_lui};

    initial begin
        rst = 1'b1; stall_d = 1'b0; flush_e = 1'b0;
        zero_e = 1'b0; lt_e = 1'b0; ltu_e = 1'b0;
        put(1'b0, 32'h0);
        tick(); tick();
        chk("rst_alu_ctl_e", 32'(bus1.alu_ctl_e), 32'd0);
        chk("rst_reg_write_w", 32'(bus1.reg_write_w), 32'd0);
        chk("rst_illegal_cnt", 32'(bus1.illegal_cnt), 32'd0);
        rst = 1'b0;

        // add x3,x1,x2 through all stages
        put(1'b1, c_add); #1;
        chk("add_imm_src_d", 32'(bus1.imm_src_d), 32'd0);
        tick(); put(1'b0, 32'h0);
        chk("add_alu_ctl_e", 32'(bus1.alu_ctl_e), 32'd0);
        tick();
        chk("add_reg_write_m", 32'(bus1.reg_write_m), 32'd1);
        tick();
        chk("add_reg_write_w", 32'(bus1.reg_write_w), 32'd1);
        chk("add_result_src_w", 32'(bus1.result_src_w), 32'd0);

        // branch resolution
        put(1'b1, c_beq); tick(); put(1'b0, 32'h0);
        zero_e = 1'b1; #1;
        chk("beq_taken", 32'(bus1.pc_src_e), 32'd1);
        zero_e = 1'b0; #1;
        chk("beq_not_taken", 32'(bus1.pc_src_e), 32'd0);
        put(1'b1, c_bltu); tick(); put(1'b0, 32'h0);
        ltu_e = 1'b1; #1;
        chk("bltu_taken", 32'(bus1.pc_src_e), 32'd1);
        ltu_e = 1'b0;

        // lw held in D for two cycles
        put(1'b1, c_lw); stall_d = 1'b1;
        tick(); chk("stall_bubble1", 32'(bus1.alu_src_e), 32'd0);
        tick(); chk("stall_bubble2", 32'(bus1.alu_src_e), 32'd0);
        stall_d = 1'b0;
        tick(); put(1'b0, 32'h0);
        chk("lw_alu_src_e", 32'(bus1.alu_src_e), 32'd1);
        tick(); tick();
        chk("lw_result_src_w", 32'(bus1.result_src_w), 32'd1);

        // sweep of encodings with varying flags and occasional flush
        for (int i = 0; i < 24; i++) begin
            put(1'b1, tbl[i]);
            flush_e = (i % 7 == 3);
            tick();
            zero_e = i[0]; lt_e = i[1]; ltu_e = i[2];
        end
        flush_e = 1'b0; put(1'b0, 32'h0);
        tick(); tick(); tick();

        // illegal counting
        do_reset();
        put(1'b1, c_op7f); #1;
        chk("op7f_illegal_d", 32'(bus1.illegal_d), 32'd1);
        tick(); put(1'b1, c_b010); #1;
        chk("b010_illegal_d", 32'(bus1.illegal_d), 32'd1);
        tick(); put(1'b0, 32'h0);
        chk("illegal_cnt_2", 32'(bus1.illegal_cnt), 32'd2);
        put(1'b1, c_op7f); stall_d = 1'b1; flush_e = 1'b1;
        tick(); stall_d = 1'b0; flush_e = 1'b0; put(1'b0, 32'h0);
        chk("stall_flush_no_cnt", 32'(bus1.illegal_cnt), 32'd2);
        put(1'b1, c_op7f); stall_d = 1'b1;
        tick(); tick();
        chk("stalled_not_cnt", 32'(bus1.illegal_cnt), 32'd2);
        stall_d = 1'b0;
        tick(); put(1'b0, 32'h0);
        chk("released_cnt", 32'(bus1.illegal_cnt), 32'd3);

        // saturation of the 2-bit counter
        do_reset();
        put(1'b1, c_op7f);
        repeat (5) tick();
        put(1'b0, 32'h0);
        chk("cnt2_saturated", 32'(bus2.illegal_cnt), 32'd3);
        chk("cnt16_five", 32'(bus1.illegal_cnt), 32'd5);

        // jumps disabled
        put(1'b1, c_jal); #1;
        chk("nojump_jal_illegal", 32'(bus3.illegal_d), 32'd1);
        chk("jal_legal", 32'(bus1.illegal_d), 32'd0);
        tick();

        // reset with sw in M and jal in E
        put(1'b1, c_sw); tick();
        put(1'b1, c_jal); tick();
        put(1'b0, 32'h0); #1;
        chk("sw_mem_write_m", 32'(bus1.mem_write_m), 32'd1);
        chk("jal_pc_src_e", 32'(bus1.pc_src_e), 32'd1);
        rst = 1'b1;
        tick();
        chk("rst_mem_write_m", 32'(bus1.mem_write_m), 32'd0);
        chk("rst_pc_src_e", 32'(bus1.pc_src_e), 32'd0);
        chk("rst_reg_write_m", 32'(bus1.reg_write_m), 32'd0);
        chk("rst_cnt", 32'(bus1.illegal_cnt), 32'd0);
        rst = 1'b0;
        tick(); tick();
        chk("post_rst_reg_write_w", 32'(bus1.reg_write_w), 32'd0);
        chk("post_rst_result_src_w", 32'(bus1.result_src_w), 32'd0);

        tick();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not complete, got %0d/%0d", n_pass, n_chk);
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/ctrl_pipe.md
# ctrl_pipe

Pipelined control path for the 5-stage RV32I core. It decodes the Decode-stage instruction into control fields and carries them through the ID/EX, EX/MEM and MEM/WB control registers. It resolves branch and jump redirection in Execute, inserts bubbles on stall or flush, and flags and counts illegal instructions. Compared with the single-cycle decoder, it adds funct3/funct7-based ALU control, the full branch set, jal/jalr/lui, and the pipelined control registers.

## Interface
Parameters:
- ALUCTL_W, default 3: ALU control width; encodings fit in 3 bits, and wider values zero-extend.
- CNT_W, default 16: width of the illegal-instruction counter.
- EN_JUMP, default 1: when 1, decode jal/jalr/lui; when 0, these opcodes are illegal.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  reset; synchronous, active-high
- valid_d  in  1  instr_d holds a real instruction
- instr_d  in  32  Decode-stage instruction
- stall_d  in  1  hazard unit holds F/D; E receives a bubble
- flush_e  in  1  kill the instruction entering E
- zero_e, lt_e, ltu_e  in  1 each  ALU flags for the instruction in E
- illegal_d  out  1  combinational; valid_d and the opcode or encoding is unsupported
- alu_ctl_e  out  ALUCTL_W  ALU operation in E
- alu_src_e  out  1  1 selects the immediate operand
- imm_src_d  out  3  immediate format in D: I=0, S=1, B=2, J=3, U=4
- pc_src_e  out  1  redirect fetch to the branch/jump target
- jalr_e  out  1  target is rs1+imm rather than pc+imm
- reg_write_m, mem_write_m  out  1 each
- reg_write_w  out  1
- result_src_w  out  2  writeback source: 0=ALU, 1=memory, 2=pc+4, 3=immediate (lui)
- illegal_cnt  out  CNT_W  saturating count of illegal instructions

## Operation
Decode is combinational from opcode[6:0], funct3 and funct7[5].
- R (0110011): reg_write=1. funct3 maps add/sub (funct7[5])=0/1, and=2, or=3, xor=4, slt=5, sll=6, srl=7.
- I-ALU (0010011): as R with alu_src=1. funct7[5] is ignored except for srai, which is illegal. sub is never produced.
- lw (0000011, funct3=010): reg_write=1, alu_src=1, result_src=1, alu_ctl=add.
- sw (0100011, funct3=010): mem_write=1, alu_src=1, imm=S.
- branch (1100011): alu_ctl=sub, imm=B. funct3 must be 000, 001, 100, 101, 110 or 111; any other value is illegal.
- jal (1101111): reg_write=1, result_src=2, jump.
- jalr (1100111, funct3=000): as jal with jalr=1 and alu_src=1.
- lui (0110111): reg_write=1, result_src=3, imm=U.

Illegal encodings and all undecoded opcodes produce all-zero controls plus illegal_d=1. The all-zero control word is the bubble.

Control registers:
- E register (reg_write, mem_write, result_src, alu_ctl, alu_src, branch, funct3, jump, jalr) loads the bubble when rst, flush_e, stall_d or !valid_d is high. Otherwise it loads the decoded word.
- M and W registers always advance and clear only on rst.

Branch resolution in E:
- taken = beq:zero, bne:!zero, blt:lt, bge:!lt, bltu:ltu, bgeu:!ltu.
- pc_src_e = (branch_e & taken) | jump_e.
- pc_src_e does not flush anything internally; the hazard unit turns it into flush_e and flush of D.

Illegal counter:
- Increments by 1 when illegal_d & !stall_d & !flush_e.
- Saturates at all-ones.
- Clears on rst.

## Timing
- Decode outputs (illegal_d, imm_src_d) are combinational in D.
- E outputs appear 1 cycle after D, M outputs after 2 cycles, W outputs after 3 cycles.
- All registered outputs and illegal_cnt are 0 in the cycle after rst is high. rst asserted mid-stream discards every in-flight control word.
- stall_d and flush_e together give a bubble, and the counter does not increment.
- A stalled instruction is counted once, in the cycle it is released.
- pc_src_e is combinational from the E register and the flags, with no extra latency.

## Structure
- Shared package ctrl_pkg holds:
  - opcode constants
  - ALU control encodings
  - imm_src and result_src encodings
  - a packed struct for the control word, with its bubble constant
- One combinational sub-module, ctrl_decode (D-stage decode and illegal detection).
- The pipeline registers and counter live in ctrl_pipe.

## Test plan
- add x3,x1,x2 (0x002081B3) at valid_d -> alu_ctl_e=0 next cycle; reg_write_w=1, result_src_w=0 three cycles later.
- beq with zero_e=1 -> pc_src_e=1. The same beq with zero_e=0 -> pc_src_e=0. bltu with ltu_e=1 -> pc_src_e=1.
- lw with stall_d=1 for 2 cycles -> E shows the bubble for 2 cycles, then lw controls with result_src=1, reaching result_src_w=1 three cycles after release.
- Opcode 0x7F, then funct3=010 on a branch -> illegal_d=1 each time and illegal_cnt=2.
- CNT_W=2 with five illegal instructions -> illegal_cnt holds at 3. EN_JUMP=0 with jal -> illegal_d=1.
- rst asserted with sw in M and jal in E -> all outputs 0 the next cycle; nothing is written afterward.
